// File: rtl/viterbi_pkg.sv
// Shared types, default code parameters and parity helper for the Viterbi encoder/decoder pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package viterbi_pkg;

    // Encoder frame FSM states
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_state_t;

    // Default code: K=3, (7,5) octal generators, 256-bit frames
    localparam int         K_DEF         = 3;
    localparam logic [2:0] G0_DEF        = 3'b111;
    localparam logic [2:0] G1_DEF        = 3'b101;
    localparam int         FRAME_LEN_DEF = 256;

    // Widest constraint length supported by the helper below
    localparam int         K_MAX         = 7;

    // Parity of the tapped bits of an encoding vector; narrower vectors are zero-extended
    function automatic logic parity_g(input logic [K_MAX-1:0] u, input logic [K_MAX-1:0] g);
        return ^(u & g);
    endfunction

endpackage

// File: rtl/conv_encoder_framed.sv
// Rate-1/2 framed convolutional encoder: FRAME_LEN info bits plus K-1 zero tail bits per frame.
// Latency: one cycle from accepted bit (or tail step) to registered dibit on d_out/valid_o.
// Backpressure: none on the output; ready_o drops only during the K-1 tail cycles.
module conv_encoder_framed
    import viterbi_pkg::*;
#(
    parameter int             K         = K_DEF,
    parameter logic [K-1:0]   G0        = K'(G0_DEF),
    parameter logic [K-1:0]   G1        = K'(G1_DEF),
    parameter int             FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_in,
    output logic       ready_o,
    output logic       valid_o,
    output logic [1:0] d_out,
    output logic       sof_o,
    output logic       eof_o,
    output logic       busy_o
);

    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(K);

    // Last count values before leaving DATA / TAIL
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);

    enc_state_t    state;
    logic [K-2:0]  sr;
    logic [BW-1:0] bit_ct;
    logic [TW-1:0] tail_ct;

    logic          accept;
    logic          fire;
    logic          cur_bit;
    logic [K-1:0]  u;

    // Handshake, step qualifier and encoding vector; tail steps force the input bit to zero
    always_comb begin
        ready_o = (state != TAIL);
        busy_o  = (state != IDLE);
        accept  = enable_i && ready_o;
        fire    = accept || (state == TAIL);
        cur_bit = (state == TAIL) ? 1'b0 : d_in;
        u       = {cur_bit, sr};
    end

    // Frame FSM, shift register, counters and registered dibit/flag outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sr      <= '0;
            bit_ct  <= '0;
            tail_ct <= '0;
            valid_o <= 1'b0;
            d_out   <= 2'b00;
            sof_o   <= 1'b0;
            eof_o   <= 1'b0;
        end else begin
            valid_o <= fire;
            sof_o   <= 1'b0;
            eof_o   <= 1'b0;

            // d_out and sr move only on a real step; bubbles leave both untouched
            if (fire) begin
                d_out <= {parity_g(K_MAX'(u), K_MAX'(G1)), parity_g(K_MAX'(u), K_MAX'(G0))};
                sr    <= u[K-1:1];
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        sof_o   <= 1'b1;
                        bit_ct  <= BW'(1);
                        tail_ct <= '0;
                        state   <= (FRAME_LEN == 1) ? TAIL : DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        bit_ct <= bit_ct + BW'(1);
                        if (bit_ct == BIT_LAST) begin
                            tail_ct <= '0;
                            state   <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    // Last tail step flushes the final past bit, leaving sr all zero
                    if (tail_ct == TAIL_LAST) begin
                        eof_o   <= 1'b1;
                        bit_ct  <= '0;
                        tail_ct <= '0;
                        state   <= IDLE;
                    end else begin
                        tail_ct <= tail_ct + TW'(1);
                    end
                end
                default: begin
                    bit_ct  <= '0;
                    tail_ct <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Self-checking bench: three encoder instances (FRAME_LEN 4, 1, 256) with a convolution reference model.
// Latency: checks each dibit one cycle after its accepted bit or tail step.
// Backpressure: random enable_i gaps; ready_o checked against the model's tail window.
module tb_conv_encoder_framed;

    localparam int KM = 3;
    localparam int FL = 256;
    localparam int NBITS = 10000;

    logic       clk;
    logic       rst;
    logic       en   [3];
    logic       din  [3];
    logic       rdy  [3];
    logic       vld  [3];
    logic [1:0] dout [3];
    logic       sof  [3];
    logic       eof  [3];
    logic       busy [3];

    int total = 0;
    int bad   = 0;

    conv_encoder_framed #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(4)) d4 (
        .clk(clk), .rst(rst), .enable_i(en[0]), .d_in(din[0]), .ready_o(rdy[0]),
        .valid_o(vld[0]), .d_out(dout[0]), .sof_o(sof[0]), .eof_o(eof[0]), .busy_o(busy[0]));

    conv_encoder_framed #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(1)) d1 (
        .clk(clk), .rst(rst), .enable_i(en[1]), .d_in(din[1]), .ready_o(rdy[1]),
        .valid_o(vld[1]), .d_out(dout[1]), .sof_o(sof[1]), .eof_o(eof[1]), .busy_o(busy[1]));

    conv_encoder_framed #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(FL)) d256 (
        .clk(clk), .rst(rst), .enable_i(en[2]), .d_in(din[2]), .ready_o(rdy[2]),
        .valid_o(vld[2]), .d_out(dout[2]), .sof_o(sof[2]), .eof_o(eof[2]), .busy_o(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, want);
        end
    endtask

    // Per-cycle record: expected outputs at the sample point, then inputs driven for that cycle
    typedef struct {
        logic       v;
        logic [1:0] d;
        logic       s;
        logic       e;
        logic       b;
        logic       r;
        logic       en;
        logic       din;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(logic v, logic [1:0] d, logic s, logic e, logic b, logic r,
                                logic en_v, logic din_v);
        row_t x;
        x.v = v; x.d = d; x.s = s; x.e = e; x.b = b; x.r = r; x.en = en_v; x.din = din_v;
        return x;
    endfunction

    task automatic apply_rows(input int di, input string tag);
        for (int i = 0; i < rows.size(); i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d] valid", tag, i), 8'(vld[di]),  8'(rows[i].v));
            if (rows[i].v)
                chk($sformatf("%s[%0d] d_out", tag, i), 8'(dout[di]), 8'(rows[i].d));
            chk($sformatf("%s[%0d] sof", tag, i),   8'(sof[di]),  8'(rows[i].s));
            chk($sformatf("%s[%0d] eof", tag, i),   8'(eof[di]),  8'(rows[i].e));
            chk($sformatf("%s[%0d] busy", tag, i),  8'(busy[di]), 8'(rows[i].b));
            chk($sformatf("%s[%0d] ready", tag, i), 8'(rdy[di]),  8'(rows[i].r));
            en[di]  = rows[i].en;
            din[di] = rows[i].din;
        end
    endtask

    // Reference model: bits of the current frame (tail zeros appended as they are emitted)
    bit fq[$];
    logic [2:0] g0m;
    logic [2:0] g1m;

    // Output n of the code as a direct convolution over the frame's bit sequence
    function automatic logic [1:0] conv(input int n);
        logic p0;
        logic p1;
        p0 = 1'b0;
        p1 = 1'b0;
        for (int j = 0; j < KM; j++) begin
            if (n - j >= 0) begin
                p0 = p0 ^ (g0m[KM-1-j] & fq[n-j]);
                p1 = p1 ^ (g1m[KM-1-j] & fq[n-j]);
            end
        end
        return {p1, p0};
    endfunction

    typedef struct {
        logic [1:0] d;
        logic       s;
        logic       e;
    } exp_t;

    exp_t eq[$];

    initial begin
        int   nbits;
        int   tail_left;
        int   frames;
        int   eofs_seen;
        logic exp_v;
        logic e_r;
        logic b_r;
        exp_t x;
        exp_t got;

        g0m = 3'b111;
        g1m = 3'b101;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i]  = 1'b0;
            din[i] = 1'b0;
        end

        // Reset values on every instance
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset[%0d] valid", i), 8'(vld[i]),  8'd0);
            chk($sformatf("reset[%0d] d_out", i), 8'(dout[i]), 8'd0);
            chk($sformatf("reset[%0d] sof", i),   8'(sof[i]),  8'd0);
            chk($sformatf("reset[%0d] eof", i),   8'(eof[i]),  8'd0);
            chk($sformatf("reset[%0d] busy", i),  8'(busy[i]), 8'd0);
            chk($sformatf("reset[%0d] ready", i), 8'(rdy[i]),  8'd1);
        end
        #20;
        rst = 1'b1;

        // FRAME_LEN=4: bits 1,0,1,1 -> 11,01,00,10 + tail 10,11
        rows.delete();
        rows.push_back(mk(0, 2'd0, 0, 0, 0, 1, 1, 1));
        rows.push_back(mk(1, 2'd3, 1, 0, 1, 1, 1, 0));
        rows.push_back(mk(1, 2'd1, 0, 0, 1, 1, 1, 1));
        rows.push_back(mk(1, 2'd0, 0, 0, 1, 1, 1, 1));
        rows.push_back(mk(1, 2'd2, 0, 0, 1, 0, 0, 0));
        rows.push_back(mk(1, 2'd2, 0, 0, 1, 0, 0, 0));
        rows.push_back(mk(1, 2'd3, 0, 1, 0, 1, 0, 0));
        rows.push_back(mk(0, 2'd0, 0, 0, 0, 1, 0, 0));
        apply_rows(0, "frame4");

        // Same frame with a two-cycle bubble after the second bit
        rows.delete();
        rows.push_back(mk(0, 2'd0, 0, 0, 0, 1, 1, 1));
        rows.push_back(mk(1, 2'd3, 1, 0, 1, 1, 1, 0));
        rows.push_back(mk(1, 2'd1, 0, 0, 1, 1, 0, 0));
        rows.push_back(mk(0, 2'd0, 0, 0, 1, 1, 0, 0));
        rows.push_back(mk(0, 2'd0, 0, 0, 1, 1, 1, 1));
        rows.push_back(mk(1, 2'd0, 0, 0, 1, 1, 1, 1));
        rows.push_back(mk(1, 2'd2, 0, 0, 1, 0, 0, 0));
        rows.push_back(mk(1, 2'd2, 0, 0, 1, 0, 0, 0));
        rows.push_back(mk(1, 2'd3, 0, 1, 0, 1, 0, 0));
        rows.push_back(mk(0, 2'd0, 0, 0, 0, 1, 0, 0));
        apply_rows(0, "bubble");

        // Back-to-back all-ones frames with enable held high through the tail
        rows.delete();
        rows.push_back(mk(0, 2'd0, 0, 0, 0, 1, 1, 1));
        rows.push_back(mk(1, 2'd3, 1, 0, 1, 1, 1, 1));
        rows.push_back(mk(1, 2'd2, 0, 0, 1, 1, 1, 1));
        rows.push_back(mk(1, 2'd1, 0, 0, 1, 1, 1, 1));
        rows.push_back(mk(1, 2'd1, 0, 0, 1, 0, 1, 1));
        rows.push_back(mk(1, 2'd2, 0, 0, 1, 0, 1, 1));
        rows.push_back(mk(1, 2'd3, 0, 1, 0, 1, 1, 1));
        rows.push_back(mk(1, 2'd3, 1, 0, 1, 1, 1, 1));
        rows.push_back(mk(1, 2'd2, 0, 0, 1, 1, 1, 1));
        rows.push_back(mk(1, 2'd1, 0, 0, 1, 1, 1, 1));
        rows.push_back(mk(1, 2'd1, 0, 0, 1, 0, 1, 1));
        rows.push_back(mk(1, 2'd2, 0, 0, 1, 0, 0, 0));
        rows.push_back(mk(1, 2'd3, 0, 1, 0, 1, 0, 0));
        rows.push_back(mk(0, 2'd0, 0, 0, 0, 1, 0, 0));
        apply_rows(0, "b2b");

        // FRAME_LEN=1: bit 1 -> 11,01,11
        rows.delete();
        rows.push_back(mk(0, 2'd0, 0, 0, 0, 1, 1, 1));
        rows.push_back(mk(1, 2'd3, 1, 0, 1, 0, 0, 0));
        rows.push_back(mk(1, 2'd1, 0, 0, 1, 0, 0, 0));
        rows.push_back(mk(1, 2'd3, 0, 1, 0, 1, 0, 0));
        rows.push_back(mk(0, 2'd0, 0, 0, 0, 1, 0, 0));
        apply_rows(1, "frame1");

        // Asynchronous reset after two bits of a frame, then a fresh frame from sr=0
        @(posedge clk); #1;
        en[0] = 1'b1; din[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst pre valid", 8'(vld[0]), 8'd1);
        en[0] = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst valid", 8'(vld[0]),  8'd0);
        chk("midrst d_out", 8'(dout[0]), 8'd0);
        chk("midrst sof",   8'(sof[0]),  8'd0);
        chk("midrst eof",   8'(eof[0]),  8'd0);
        chk("midrst busy",  8'(busy[0]), 8'd0);
        chk("midrst ready", 8'(rdy[0]),  8'd1);
        chk("midrst sr",    8'(d4.sr),   8'd0);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("postrst idle valid", 8'(vld[0]), 8'd0);
        en[0] = 1'b1; din[0] = 1'b1;
        @(posedge clk); #1;
        en[0] = 1'b0;
        chk("postrst valid", 8'(vld[0]),  8'd1);
        chk("postrst d_out", 8'(dout[0]), 8'd3);
        chk("postrst sof",   8'(sof[0]),  8'd1);

        // Random traffic on the FRAME_LEN=256 instance against the convolution model
        nbits     = 0;
        tail_left = 0;
        frames    = 0;
        eofs_seen = 0;
        exp_v     = 1'b0;
        fq.delete();
        eq.delete();
        while (nbits < NBITS || tail_left > 0 || exp_v) begin
            @(posedge clk); #1;
            chk("rand ready", 8'(rdy[2]), 8'(tail_left == 0));
            chk("rand valid", 8'(vld[2]), 8'(exp_v));
            if (vld[2] === 1'b1) begin
                if (eq.size() == 0) begin
                    chk("rand unexpected dibit", 8'd1, 8'd0);
                end else begin
                    got = eq.pop_front();
                    chk("rand d_out", 8'(dout[2]), 8'(got.d));
                    chk("rand sof",   8'(sof[2]),  8'(got.s));
                    chk("rand eof",   8'(eof[2]),  8'(got.e));
                end
                if (eof[2] === 1'b1) begin
                    eofs_seen++;
                    chk("rand sr at eof", 8'(d256.sr), 8'd0);
                end
            end

            e_r = (nbits < NBITS) && ($urandom_range(0, 3) != 0);
            b_r = 1'($urandom_range(0, 1));
            en[2]  = e_r;
            din[2] = b_r;

            if (tail_left > 0) begin
                fq.push_back(1'b0);
                x.d = conv(fq.size() - 1);
                x.s = 1'b0;
                x.e = (fq.size() == FL + KM - 1);
                eq.push_back(x);
                if (x.e) begin
                    fq.delete();
                    frames++;
                end
                tail_left--;
                exp_v = 1'b1;
            end else if (e_r) begin
                fq.push_back(b_r);
                x.d = conv(fq.size() - 1);
                x.s = (fq.size() == 1);
                x.e = 1'b0;
                eq.push_back(x);
                nbits++;
                if (fq.size() == FL)
                    tail_left = KM - 1;
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
        end
        en[2] = 1'b0;
        @(posedge clk); #1;
        chk("rand drain valid", 8'(vld[2]), 8'd0);
        chk("rand leftover", 8'(eq.size()), 8'd0);
        chk("rand frame count", 8'(eofs_seen), 8'(frames));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
